ysyx_25020037_wbu: RTL

YSYX_25020037_WBU -- requirements
Module: ysyx_25020037_wbu

---
 rtl/ysyx_25020037_wbu_pkg.sv | 52 +++++
 rtl/ysyx_25020037_wbu_ldext.sv | 28 ++
 rtl/ysyx_25020037_wbu.sv | 95 +++++++++
 3 files changed

// File: rtl/ysyx_25020037_wbu_pkg.sv
// Shared write-back configuration: bus widths, field encodings and bus layouts
// for the LSU->WBU and WBU->register-file interfaces.
package ysyx_25020037_wbu_pkg;

  localparam int LU_TO_WU_BUS_WD = 210;
  localparam int WU_TO_GU_BUS_WD = 107;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_CSR = 2'b10;
  localparam logic [1:0] RES_PC4 = 2'b11;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COMMIT   = 2'd1;
  localparam logic [1:0] ST_WAIT_IFU = 2'd2;

  // Field order is MSB first, matching the legacy flat bus layout.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic [3:0]  rd;
    logic        gpr_wen;
    logic [1:0]  res_sel;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] csr_rdata;
    logic [31:0] csr_wdata;
    logic [3:0]  csr_wen;
    logic        ecall;
    logic        mret;
  } lu_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  rd;
    logic [3:0]  csr_wen;
    logic        ecall_en;
    logic        mret_en;
    logic [31:0] csr_wcsr_data;
    logic        gpr_wen;
    logic [31:0] gpr_wdata;
  } wu_bus_t;

endpackage

// File: rtl/ysyx_25020037_wbu_ldext.sv
// Load data extraction: selects the addressed byte/halfword lane and
// sign- or zero-extends it according to the load type.
module ysyx_25020037_wbu_ldext
  import ysyx_25020037_wbu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_type)
      LD_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      LD_LH:   ld_data = {{16{half_v[15]}}, half_v};
      LD_LW:   ld_data = mem_rdata;
      LD_LBU:  ld_data = {24'h0, byte_v};
      LD_LHU:  ld_data = {16'h0, half_v};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back unit: captures one LSU result, commits it to the register file for
// a single cycle, then holds the next PC until the IFU accepts it.
module ysyx_25020037_wbu
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lsu_valid,
  output logic                       wbu_ready,
  input  logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus,
  output logic                       wbu_valid,
  output logic [WU_TO_GU_BUS_WD-1:0] wu_to_gu_bus,
  output logic                       npc_valid,
  input  logic                       ifu_ready,
  output logic [31:0]                npc,
  output logic [CNT_W-1:0]           minstret
);

  logic [1:0]       state_q, state_d;
  lu_bus_t          bus_q, bus_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;
  logic [31:0]      ld_data;
  logic [31:0]      gpr_wdata;
  wu_bus_t          wu_bus;

  ysyx_25020037_wbu_ldext u_ldext (
    .mem_rdata (bus_q.mem_rdata),
    .ld_type   (bus_q.ld_type),
    .addr_lo   (bus_q.addr_lo),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    bus_d      = bus_q;
    minstret_d = minstret_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid) begin
          bus_d   = lu_bus_t'(lu_to_wu_bus);
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        minstret_d = minstret_q + CNT_W'(1);
        state_d    = ifu_ready ? ST_IDLE : ST_WAIT_IFU;
      end
      ST_WAIT_IFU: begin
        if (ifu_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bus_q      <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      bus_q      <= bus_d;
      minstret_q <= minstret_d;
    end
  end

  always_comb begin
    case (bus_q.res_sel)
      RES_ALU: gpr_wdata = bus_q.alu_result;
      RES_MEM: gpr_wdata = ld_data;
      RES_CSR: gpr_wdata = bus_q.csr_rdata;
      default: gpr_wdata = bus_q.pc + 32'd4;
    endcase

    wu_bus.pc            = bus_q.pc;
    wu_bus.rd            = bus_q.rd;
    wu_bus.csr_wen       = bus_q.csr_wen;
    wu_bus.ecall_en      = bus_q.ecall;
    wu_bus.mret_en       = bus_q.mret;
    wu_bus.csr_wcsr_data = bus_q.csr_wdata;
    wu_bus.gpr_wen       = bus_q.gpr_wen && (bus_q.rd != 4'd0);
    wu_bus.gpr_wdata     = gpr_wdata;
  end

  // Trap entry and return both redirect to the CSR value read alongside them.
  assign npc          = (bus_q.ecall || bus_q.mret) ? bus_q.csr_rdata : bus_q.dnpc;
  assign wu_to_gu_bus = wu_bus;
  assign wbu_ready    = (state_q == ST_IDLE);
  assign wbu_valid    = (state_q == ST_COMMIT);
  assign npc_valid    = (state_q == ST_COMMIT) || (state_q == ST_WAIT_IFU);
  assign minstret     = minstret_q;

endmodule
